// File: rtl/dac_cfg_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// dac_cfg_sequencer_pkg
// Shared FSM encoding and default sizing for the DAC configuration sequencer.
// Revision: 1.0
// ============================================================================
package dac_cfg_sequencer_pkg;

    localparam int c_default_data_width = 32;
    localparam int c_default_depth      = 16;
    localparam int c_default_gap_cycles = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/dac_cfg_table.sv
`default_nettype none
// ============================================================================
// dac_cfg_table
// DEPTH x DATA_WIDTH command table: one write port, one registered read port.
// Revision: 1.0
// ============================================================================
module dac_cfg_table #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The read register doubles as the word holding register toward the SPI master.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/dac_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// dac_cfg_sequencer
// Streams table entries 0..N-1 to the DAC SPI master with a fixed idle gap.
// Revision: 1.0
// ============================================================================
module dac_cfg_sequencer
    import dac_cfg_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int DEPTH      = c_default_depth,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = c_default_gap_cycles
) (
    input  logic                  dac_clk,
    input  logic                  rst_n,
    input  logic                  cfg_wr_en_i,
    input  logic [ADDR_W-1:0]     cfg_wr_addr_i,
    input  logic [DATA_WIDTH-1:0] cfg_wr_data_i,
    input  logic [ADDR_W:0]       num_words_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic [DATA_WIDTH-1:0] sdo_data_o,
    output logic                  sdo_valid_o,
    input  logic                  sdo_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  aborted_o,
    output logic                  wr_err_o,
    output logic [ADDR_W:0]       words_sent_o
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [7:0]      c_gap   = 8'(GAP_CYCLES);

    seq_state_t      r_state;
    logic [ADDR_W:0] r_num;
    logic [ADDR_W:0] r_index;
    logic [ADDR_W:0] r_words_sent;
    logic [7:0]      r_gap_cnt;
    logic            r_valid;
    logic            r_busy;
    logic            r_done;
    logic            r_aborted;
    logic            r_wr_err;

    logic [ADDR_W:0]   w_num_capped;
    logic              w_xfer;
    logic              w_more;
    logic              w_gap_end;
    logic              w_tbl_wr_en;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_num_capped = (num_words_i > c_depth) ? c_depth : num_words_i;
    assign w_xfer       = r_valid & sdo_ready_i;
    assign w_more       = (r_index < r_num);
    assign w_gap_end    = (r_gap_cnt == 8'd1);
    assign w_tbl_wr_en  = cfg_wr_en_i & (r_state == ST_IDLE);

    // Fetch the next word on the same edge that raises valid, so data and valid align.
    assign w_rd_en   = ((r_state == ST_IDLE) & start_i & (w_num_capped != '0))
                     | ((r_state == ST_GAP) & ~abort_i & w_gap_end & w_more);
    assign w_rd_addr = (r_state == ST_IDLE) ? '0 : r_index[ADDR_W-1:0];

    dac_cfg_table #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_table (
        .clk       (dac_clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_tbl_wr_en),
        .i_wr_addr (cfg_wr_addr_i),
        .i_wr_data (cfg_wr_data_i),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (sdo_data_o)
    );

    always_ff @(posedge dac_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_num        <= '0;
            r_index      <= '0;
            r_words_sent <= '0;
            r_gap_cnt    <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_wr_err     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_wr_err  <= cfg_wr_en_i & (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_num        <= w_num_capped;
                        r_index      <= '0;
                        r_words_sent <= '0;
                        r_busy       <= 1'b1;
                        if (w_num_capped != '0) begin
                            r_state <= ST_SEND;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    // Abort takes priority over a coincident handshake.
                    if (abort_i) begin
                        r_state   <= ST_IDLE;
                        r_valid   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else if (w_xfer) begin
                        r_index      <= r_index + 1'b1;
                        r_words_sent <= r_words_sent + 1'b1;
                        r_gap_cnt    <= c_gap;
                        r_valid      <= 1'b0;
                        r_state      <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (abort_i) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else if (w_gap_end) begin
                        if (w_more) begin
                            r_state <= ST_SEND;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sdo_valid_o  = r_valid;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign aborted_o    = r_aborted;
    assign wr_err_o     = r_wr_err;
    assign words_sent_o = r_words_sent;

endmodule
`default_nettype wire

// File: tb/tb_dac_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// tb_dac_cfg_sequencer
// Directed bench for the DAC configuration sequencer (GAP_CYCLES = 8).
// Revision: 1.0
// ============================================================================
module tb_dac_cfg_sequencer;

    logic        dac_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_wr_en_i = 1'b0;
    logic [3:0]  cfg_wr_addr_i = '0;
    logic [31:0] cfg_wr_data_i = '0;
    logic [4:0]  num_words_i = '0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [31:0] sdo_data_o;
    logic        sdo_valid_o;
    logic        sdo_ready_i = 1'b1;
    logic        busy_o;
    logic        done_o;
    logic        aborted_o;
    logic        wr_err_o;
    logic [4:0]  words_sent_o;

    dac_cfg_sequencer #(
        .DATA_WIDTH (32),
        .DEPTH      (16),
        .ADDR_W     (4),
        .GAP_CYCLES (8)
    ) dut (
        .dac_clk       (dac_clk),
        .rst_n         (rst_n),
        .cfg_wr_en_i   (cfg_wr_en_i),
        .cfg_wr_addr_i (cfg_wr_addr_i),
        .cfg_wr_data_i (cfg_wr_data_i),
        .num_words_i   (num_words_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .sdo_data_o    (sdo_data_o),
        .sdo_valid_o   (sdo_valid_o),
        .sdo_ready_i   (sdo_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .aborted_o     (aborted_o),
        .wr_err_o      (wr_err_o),
        .words_sent_o  (words_sent_o)
    );

    always #5 dac_clk = ~dac_clk;

    int          total = 0;
    int          bad = 0;
    int          xfer_cyc[$];
    logic [31:0] xfer_dat[$];
    int          done_cnt, done_at, abort_cnt, abort_seen, valid_cnt, end_cyc, stable_viol;
    bit          timed_out;
    logic [31:0] exp_tbl [16];

    task automatic tick();
        @(posedge dac_clk);
        #1;
    endtask

    task automatic write_entry(input int a, input logic [31:0] d);
        cfg_wr_en_i   = 1'b1;
        cfg_wr_addr_i = a[3:0];
        cfg_wr_data_i = d;
        exp_tbl[a]    = d;
        tick();
        cfg_wr_en_i   = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        num_words_i = n[4:0];
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
    endtask

    // Observes one sequence; window c=1 is the first cycle after the start edge.
    task automatic capture(input int max_cyc, input int rdy_lo, input int rdy_hi, input int abort_at);
        logic        prev_pend;
        logic        prev_abort;
        logic [31:0] prev_dat;
        xfer_cyc.delete();
        xfer_dat.delete();
        done_cnt = 0; done_at = -1; abort_cnt = 0; abort_seen = -1;
        valid_cnt = 0; end_cyc = -1; stable_viol = 0; timed_out = 1'b1;
        prev_pend = 1'b0; prev_abort = 1'b0; prev_dat = '0;
        for (int c = 1; c <= max_cyc; c++) begin
            sdo_ready_i = !(c >= rdy_lo && c <= rdy_hi);
            abort_i     = (c == abort_at);
            if (sdo_valid_o) begin
                valid_cnt++;
                if (prev_pend && sdo_data_o !== prev_dat) stable_viol++;
            end else if (prev_pend && !prev_abort) begin
                stable_viol++;
            end
            if (done_o) begin done_cnt++; done_at = c; end
            if (aborted_o) begin abort_cnt++; abort_seen = c; end
            if (!busy_o) begin end_cyc = c; timed_out = 1'b0; break; end
            if (sdo_valid_o && sdo_ready_i) begin
                xfer_cyc.push_back(c);
                xfer_dat.push_back(sdo_data_o);
            end
            prev_pend  = sdo_valid_o && !sdo_ready_i;
            prev_abort = abort_i;
            prev_dat   = sdo_data_o;
            tick();
        end
        abort_i     = 1'b0;
        sdo_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (sdo_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", sdo_valid_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_o); end
        total++; if (aborted_o !== 1'b0) begin bad++; $display("FAIL reset_aborted: got %b want 0", aborted_o); end
        total++; if (wr_err_o !== 1'b0) begin bad++; $display("FAIL reset_wr_err: got %b want 0", wr_err_o); end
        total++; if (sdo_data_o !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", sdo_data_o); end
        total++; if (words_sent_o !== 5'd0) begin bad++; $display("FAIL reset_words: got %0d want 0", words_sent_o); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        write_entry(0, 32'h0300_0001);
        write_entry(1, 32'h0310_8000);
        write_entry(2, 32'h0320_FFFF);
        pulse_start(3);
        capture(200, 0, -1, 0);
        total++; if (timed_out) begin bad++; $display("FAIL basic_timeout: got timeout want end"); end
        total++; if (xfer_cyc.size() !== 3) begin bad++; $display("FAIL basic_count: got %0d want 3", xfer_cyc.size()); end
        if (xfer_cyc.size() == 3) begin
            total++; if (xfer_cyc[0] !== 1 || xfer_cyc[1] !== 10 || xfer_cyc[2] !== 19) begin
                bad++; $display("FAIL basic_timing: got %0d,%0d,%0d want 1,10,19", xfer_cyc[0], xfer_cyc[1], xfer_cyc[2]);
            end
            total++; if (xfer_dat[0] !== 32'h0300_0001 || xfer_dat[1] !== 32'h0310_8000 || xfer_dat[2] !== 32'h0320_FFFF) begin
                bad++; $display("FAIL basic_data: got %h,%h,%h want 03000001,03108000,0320ffff", xfer_dat[0], xfer_dat[1], xfer_dat[2]);
            end
        end
        total++; if (done_cnt !== 1 || done_at !== 28) begin bad++; $display("FAIL basic_done: got cnt=%0d at=%0d want cnt=1 at=28", done_cnt, done_at); end
        total++; if (end_cyc !== 29) begin bad++; $display("FAIL basic_busy_drop: got %0d want 29", end_cyc); end
        total++; if (words_sent_o !== 5'd3) begin bad++; $display("FAIL basic_words: got %0d want 3", words_sent_o); end
    endtask

    task automatic test_backpressure();
        pulse_start(3);
        capture(300, 10, 29, 0);
        total++; if (xfer_cyc.size() !== 3) begin bad++; $display("FAIL bp_count: got %0d want 3", xfer_cyc.size()); end
        if (xfer_cyc.size() == 3) begin
            total++; if (xfer_cyc[1] !== 30) begin bad++; $display("FAIL bp_xfer_cyc: got %0d want 30", xfer_cyc[1]); end
            total++; if (xfer_dat[1] !== 32'h0310_8000) begin bad++; $display("FAIL bp_data: got %h want 03108000", xfer_dat[1]); end
        end
        total++; if (stable_viol !== 0) begin bad++; $display("FAIL bp_stable: got %0d violations want 0", stable_viol); end
        total++; if (valid_cnt !== 23) begin bad++; $display("FAIL bp_valid_cycles: got %0d want 23", valid_cnt); end
        total++; if (done_at !== 48) begin bad++; $display("FAIL bp_done_at: got %0d want 48", done_at); end
    endtask

    task automatic test_zero_and_cap();
        pulse_start(0);
        capture(20, 0, -1, 0);
        total++; if (valid_cnt !== 0) begin bad++; $display("FAIL zero_valid: got %0d want 0", valid_cnt); end
        total++; if (done_cnt !== 1 || done_at !== 1) begin bad++; $display("FAIL zero_done: got cnt=%0d at=%0d want cnt=1 at=1", done_cnt, done_at); end
        total++; if (words_sent_o !== 5'd0) begin bad++; $display("FAIL zero_words: got %0d want 0", words_sent_o); end
        for (int i = 3; i < 16; i++) write_entry(i, 32'h0330_0000 + i);
        pulse_start(20);
        capture(400, 0, -1, 0);
        total++; if (xfer_cyc.size() !== 16) begin bad++; $display("FAIL cap_count: got %0d want 16", xfer_cyc.size()); end
        if (xfer_cyc.size() == 16) begin
            total++; if (xfer_dat[15] !== 32'h0330_000F || xfer_dat[3] !== 32'h0330_0003) begin
                bad++; $display("FAIL cap_data: got %h,%h want 0330000f,03300003", xfer_dat[15], xfer_dat[3]);
            end
        end
        total++; if (words_sent_o !== 5'd16) begin bad++; $display("FAIL cap_words: got %0d want 16", words_sent_o); end
        total++; if (done_at !== 145) begin bad++; $display("FAIL cap_done_at: got %0d want 145", done_at); end
    endtask

    task automatic test_abort();
        int late_done;
        pulse_start(3);
        capture(100, 11, 1000, 19);
        total++; if (xfer_cyc.size() !== 2) begin bad++; $display("FAIL abort_xfers: got %0d want 2", xfer_cyc.size()); end
        total++; if (valid_cnt !== 3) begin bad++; $display("FAIL abort_valid_cycles: got %0d want 3", valid_cnt); end
        total++; if (abort_cnt !== 1 || abort_seen !== 20) begin bad++; $display("FAIL abort_pulse: got cnt=%0d at=%0d want cnt=1 at=20", abort_cnt, abort_seen); end
        total++; if (end_cyc !== 20 || sdo_valid_o !== 1'b0) begin bad++; $display("FAIL abort_idle: got end=%0d valid=%b want end=20 valid=0", end_cyc, sdo_valid_o); end
        total++; if (words_sent_o !== 5'd2) begin bad++; $display("FAIL abort_words: got %0d want 2", words_sent_o); end
        late_done = done_cnt;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done_o) late_done++;
        end
        total++; if (late_done !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", late_done); end
        pulse_start(3);
        capture(200, 0, -1, 0);
        total++; if (xfer_cyc.size() !== 3 || xfer_dat[0] !== 32'h0300_0001) begin
            bad++; $display("FAIL abort_restart: got n=%0d first=%h want n=3 first=03000001", xfer_cyc.size(), (xfer_dat.size() > 0) ? xfer_dat[0] : 32'hx);
        end
    endtask

    task automatic test_gap_write();
        pulse_start(3);
        tick();
        tick();
        cfg_wr_en_i   = 1'b1;
        cfg_wr_addr_i = 4'd0;
        cfg_wr_data_i = 32'hDEAD_BEEF;
        num_words_i   = 5'd1;
        start_i       = 1'b1;
        tick();
        cfg_wr_en_i = 1'b0;
        start_i     = 1'b0;
        total++; if (wr_err_o !== 1'b1) begin bad++; $display("FAIL gap_wr_err: got %b want 1", wr_err_o); end
        total++; if (busy_o !== 1'b1 || sdo_valid_o !== 1'b0) begin bad++; $display("FAIL gap_state: got busy=%b valid=%b want 1,0", busy_o, sdo_valid_o); end
        capture(200, 0, -1, 0);
        total++; if (xfer_cyc.size() !== 2) begin bad++; $display("FAIL gap_remaining: got %0d want 2", xfer_cyc.size()); end
        if (xfer_cyc.size() == 2) begin
            total++; if (xfer_cyc[0] !== 7 || xfer_dat[0] !== 32'h0310_8000) begin
                bad++; $display("FAIL gap_next_word: got cyc=%0d data=%h want cyc=7 data=03108000", xfer_cyc[0], xfer_dat[0]);
            end
        end
        total++; if (done_cnt !== 1 || words_sent_o !== 5'd3) begin bad++; $display("FAIL gap_done: got cnt=%0d words=%0d want 1,3", done_cnt, words_sent_o); end
        pulse_start(1);
        capture(100, 0, -1, 0);
        total++; if (xfer_dat.size() !== 1 || xfer_dat[0] !== 32'h0300_0001) begin
            bad++; $display("FAIL gap_table_kept: got n=%0d data=%h want n=1 data=03000001", xfer_dat.size(), (xfer_dat.size() > 0) ? xfer_dat[0] : 32'hx);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start(3);
        repeat (4) tick();
        total++; if (busy_o !== 1'b1 || sdo_data_o !== 32'h0300_0001) begin
            bad++; $display("FAIL rmid_pre: got busy=%b data=%h want 1,03000001", busy_o, sdo_data_o);
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy_o !== 1'b0 || sdo_valid_o !== 1'b0 || done_o !== 1'b0 || aborted_o !== 1'b0) begin
            bad++; $display("FAIL rmid_flags: got busy=%b valid=%b done=%b aborted=%b want 0000", busy_o, sdo_valid_o, done_o, aborted_o);
        end
        total++; if (sdo_data_o !== 32'h0 || words_sent_o !== 5'd0) begin
            bad++; $display("FAIL rmid_data: got data=%h words=%0d want 0,0", sdo_data_o, words_sent_o);
        end
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start(1);
        capture(100, 0, -1, 0);
        total++; if (xfer_dat.size() !== 1 || xfer_dat[0] !== 32'h0) begin
            bad++; $display("FAIL rmid_cleared: got n=%0d data=%h want n=1 data=0", xfer_dat.size(), (xfer_dat.size() > 0) ? xfer_dat[0] : 32'hx);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_and_cap();
        test_abort();
        test_gap_write();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dac_cfg_sequencer.md
# dac_cfg_sequencer

Autonomous configuration sequencer that feeds the write-only 32-bit DAC SPI master with a programmed list of command words. It holds a small register-file table loaded through a simple write port and, on a start pulse, presents entries 0..N-1 one at a time on a valid/ready word interface. It enforces a programmable idle gap between words, so the whole DAC power-up and bias sequence runs without per-word manual toggling.

## Interface
Parameters:
- DATA_WIDTH, 32, command word width; matches the SPI master word width.
- DEPTH, 16, number of table entries.
- ADDR_W, 4, table address width; DEPTH = 2**ADDR_W.
- GAP_CYCLES, 8, idle cycles inserted after each accepted word; legal range 1..255.

Ports:
- dac_clk, in, 1, single clock for the block.
- rst_n, in, 1, asynchronous active-low reset.
- cfg_wr_en_i, in, 1, table write strobe.
- cfg_wr_addr_i, in, ADDR_W, table write address.
- cfg_wr_data_i, in, DATA_WIDTH, table write data.
- num_words_i, in, ADDR_W+1, number of words to send; sampled on start.
- start_i, in, 1, one-cycle start pulse.
- abort_i, in, 1, one-cycle abort pulse.
- sdo_data_o, out, DATA_WIDTH, word to the SPI master.
- sdo_valid_o, out, 1, word valid.
- sdo_ready_i, in, 1, SPI master can accept a word.
- busy_o, out, 1, sequence in progress.
- done_o, out, 1, one-cycle pulse when a sequence completes.
- aborted_o, out, 1, one-cycle pulse when a sequence is aborted.
- wr_err_o, out, 1, one-cycle pulse when a table write is rejected.
- words_sent_o, out, ADDR_W+1, count of words accepted in the current or last sequence.

## Operation
- FSM states are IDLE, SEND, GAP and FINISH.
- IDLE:
  - A start_i pulse latches the word count N as min(num_words_i, DEPTH) and clears the index and words_sent_o.
  - If N > 0, go to SEND. If N == 0, go to FINISH.
- SEND:
  - sdo_valid_o = 1 and sdo_data_o = table[index].
  - A transfer occurs when sdo_valid_o && sdo_ready_i in the same cycle.
  - On transfer: increment index and words_sent_o, load the gap counter with GAP_CYCLES, go to GAP.
  - sdo_valid_o and sdo_data_o stay stable until the transfer (except on abort).
- GAP:
  - The counter decrements each cycle. When it reaches 1, go to SEND if index < N, else go to FINISH.
- FINISH:
  - done_o = 1 for one cycle, then go to IDLE.
- busy_o = 1 in SEND, GAP and FINISH.
- Table writes:
  - Accepted only in IDLE, and take effect the next cycle.
  - cfg_wr_en_i in any other state leaves the table unchanged and pulses wr_err_o the next cycle.
- start_i while busy is ignored.
- abort_i in SEND or GAP:
  - The next cycle is IDLE, sdo_valid_o is 0 and aborted_o pulses.
  - A word pending in SEND is withdrawn; this is the only case in which valid drops without a transfer.
  - words_sent_o holds its value.
- abort_i in FINISH is ignored: done_o still pulses.
- abort_i and start_i together in IDLE: start wins.
- Index and counters are sized so the index never wraps; N is capped at DEPTH.
- Reset values:
  - sdo_valid_o, busy_o, done_o, aborted_o and wr_err_o are 0.
  - sdo_data_o, words_sent_o and all table entries are 0.
  - The FSM is in IDLE.
- Reset mid-sequence returns everything to the reset values immediately, with no done_o or aborted_o pulse.

## Timing
- start_i in cycle t gives sdo_valid_o = 1 in cycle t+1.
- A transfer in cycle h puts the next word's valid high in cycle h+1+GAP_CYCLES.
- A transfer of the last word in cycle h gives done_o = 1 in cycle h+1+GAP_CYCLES; busy_o drops in cycle h+2+GAP_CYCLES.
- N == 0: start in cycle t gives done_o in cycle t+1 and no valid.
- All outputs are registered; there is no combinational path from sdo_ready_i to any output.
- Table read is a registered mux.

## Structure
- The shared DAC package holds:
  - the FSM state enum;
  - default constants for DATA_WIDTH = 32, DEPTH = 16 and GAP_CYCLES = 8.
- One natural sub-module: dac_cfg_table, a DEPTH x DATA_WIDTH register file with one write port, one read port and async clear.
- The FSM and counters live in the top module.

## Test plan
- Load table[0..2] = 0x0300_0001, 0x0310_8000, 0x0320_FFFF; N = 3; sdo_ready_i held at 1 -> three single-cycle transfers in order, spaced 1+GAP_CYCLES apart, then done_o once and words_sent_o = 3.
- Backpressure: sdo_ready_i low for 20 cycles during word 1 -> sdo_valid_o and sdo_data_o (0x0310_8000) held stable, and the transfer occurs on the first ready cycle.
- num_words_i = 0 -> done_o the cycle after start with no valid. num_words_i = 20 -> exactly 16 transfers.
- Abort while word 2 is pending -> valid drops next cycle, aborted_o pulses, done_o never pulses, words_sent_o = 2. A following start resends from entry 0.
- cfg_wr_en_i during GAP -> wr_err_o pulses and the table content is unchanged; a start during GAP is ignored.
- rst_n asserted mid-GAP -> all outputs go to 0 asynchronously and the table clears; after release a start with N = 1 sends 0x0000_0000.
